dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Two-master arbiter that shares the single-port data memory between the core load/store port (master 0) and the host/loader port (master 1). Grants at most one access per cycle, returns read data one cycle after grant, and supports a lock so either master can own the memory for a back-to-back sequence. Sits between the CPU datapath and `dmem`; the core stalls on `m0_gnt == 0`.

## Interface
- `DW`, 32, data width
- `AW`, 32, address width
- `LOCK_MAX`, 16, max consecutive cycles in a locked state before a forced release (≥2)
- `clk`  in  1  clock
- `rst`  in  1  synchronous, active-high reset
- `m0_req`  in  1  master 0 access request
- `m0_we`  in  1  master 0 write enable (0 = read)
- `m0_lock`  in  1  master 0 holds ownership after this access
- `m0_addr`  in  AW  master 0 address
- `m0_wdata`  in  DW  master 0 write data
- `m0_gnt`  out  1  master 0 access accepted this cycle
- `m0_rvalid`  out  1  master 0 read data valid
- `m0_rdata`  out  DW  master 0 read data
- `m1_req`, `m1_we`, `m1_lock`, `m1_addr`, `m1_wdata`, `m1_gnt`, `m1_rvalid`, `m1_rdata`: same as master 0
- `mem_en`  out  1  memory access strobe
- `mem_we`  out  1  memory write enable
- `mem_addr`  out  AW  memory address
- `mem_wdata`  out  DW  memory write data
- `mem_rdata`  in  DW  memory read data, valid the cycle after `mem_en && !mem_we`

## Operation
- Transfer accepted when `mX_req && mX_gnt`. The master holds `req/we/lock/addr/wdata` stable until granted.
- Grant is combinational from req, state, and priority pointer `last`:
  - IDLE: a single requester is granted; if both request, the one with `last != X` wins (see Configuration).
  - OWN0 / OWN1: only the owner may be granted; the other gnt = 0.
- `last` updates to X on every accepted transfer by X.
- FSM:
  - IDLE → OWNX on an accepted transfer with `mX_lock = 1`.
  - OWNX stays on an accepted transfer with `lock = 1`, or while the owner is idle.
  - OWNX → IDLE on an accepted transfer with `lock = 0`, or on forced release.
- Lock counter:
  - Cleared on entry to OWNX; increments every cycle in OWNX.
  - Reaching `LOCK_MAX - 1` forces release: next state IDLE, `last = X`. This happens even if the cycle's transfer is accepted with `lock = 1`.
- Memory side:
  - `mem_en = m0_gnt&&m0_req | m1_gnt&&m1_req`.
  - `we/addr/wdata` are muxed from the granted master; they are 0 when no grant.
- Read response:
  - A registered tag records the master and read-vs-write of the accepted transfer.
  - The next cycle, `mX_rvalid = 1` for exactly one cycle; `mX_rdata = mem_rdata`, which is meaningful only with rvalid.
  - Writes produce no rvalid.
  - A read accepted in back-to-back cycles yields rvalid on each following cycle.

## Timing
- Grant latency: 0 cycles (same cycle as req when arbitration wins). Read latency: 1 cycle after grant.
- Throughput: one access per cycle total.
- Reset values: state IDLE, `last = 1` (master 0 wins first contention), lock counter 0, response tag cleared.
- All `gnt`, `rvalid`, and `mem_en` are 0 during and in the cycle after reset release, unless req is asserted after release.
- Reset mid-operation: a pending rvalid is dropped; lock ownership is abandoned.
- Simultaneous req in OWNX from the non-owner: waits, and gets priority on return to IDLE if `last == X`.
- `rvalid` of one master may coincide with `gnt` of the other.

## Configuration
- `DMEM_ARB_RR_EN` defined: round-robin contention in IDLE (winner is the master ≠ `last`).
- Not defined: fixed priority, where master 0 always wins contention in IDLE. `last` still updates, used only for forced-release bookkeeping. Lock and forced release behave identically in both modes.

## Test plan
- Single master: m0 reads addr 0x10 (mem holds 0xDEADBEEF) → `m0_gnt = 1` same cycle, `mem_en = 1`, `mem_addr = 0x10`; next cycle `m0_rvalid = 1`, `m0_rdata = 0xDEADBEEF`, `m1_rvalid = 0`.
- Contention, RR build: both request continuously (reads) from reset → grants alternate m0, m1, m0, m1. Fixed build: m0 granted every cycle, `m1_gnt = 0`.
- Lock: m1 writes 0x20, 0x24, 0x28 with lock = 1, 1, 0 while m0 requests → m0_gnt = 0 for those 3 cycles; m0 is granted the cycle after the lock = 0 write.
- Forced release: m1 holds req with lock = 1 for 20 cycles, `LOCK_MAX = 16`, m0 requesting → m1 granted 16 cycles, then m0 granted next cycle.
- Write no-response: m0 writes 0x55 to 0x8 → `mem_we = 1`, `mem_wdata = 0x55`; `m0_rvalid` stays 0; a subsequent read of 0x8 returns 0x55.
- Reset mid-read: assert rst in the cycle after m0 read grant → `m0_rvalid = 0`, state IDLE; the first contention after release goes to m0.

Source files
------------

// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the two data-memory masters, the arbiter and the memory.
// The slave modport is the arbiter's view; the master modport is the view of the masters plus the memory model.
interface dmem_arbiter_if #(
  parameter int DW = 32,
  parameter int AW = 32
);
  logic          m0_req;
  logic          m0_we;
  logic          m0_lock;
  logic [AW-1:0] m0_addr;
  logic [DW-1:0] m0_wdata;
  logic          m0_gnt;
  logic          m0_rvalid;
  logic [DW-1:0] m0_rdata;

  logic          m1_req;
  logic          m1_we;
  logic          m1_lock;
  logic [AW-1:0] m1_addr;
  logic [DW-1:0] m1_wdata;
  logic          m1_gnt;
  logic          m1_rvalid;
  logic [DW-1:0] m1_rdata;

  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  modport slave (
    input  m0_req, m0_we, m0_lock, m0_addr, m0_wdata,
    output m0_gnt, m0_rvalid, m0_rdata,
    input  m1_req, m1_we, m1_lock, m1_addr, m1_wdata,
    output m1_gnt, m1_rvalid, m1_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output m0_req, m0_we, m0_lock, m0_addr, m0_wdata,
    input  m0_gnt, m0_rvalid, m0_rdata,
    output m1_req, m1_we, m1_lock, m1_addr, m1_wdata,
    input  m1_gnt, m1_rvalid, m1_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-master data-memory arbiter with lock ownership and forced release after LOCK_MAX cycles.
// Optional DMEM_ARB_RR_EN selects round-robin contention in IDLE; otherwise master 0 has fixed priority.
//
// Handshake: a master holds req/we/lock/addr/wdata stable until it sees gnt; a transfer
// happens in a cycle where req && gnt. Read data arrives with rvalid exactly one cycle later.
module dmem_arbiter #(
  parameter int DW       = 32,
  parameter int AW       = 32,
  parameter int LOCK_MAX = 16
) (
  input  logic          clk,
  input  logic          rst,
  dmem_arbiter_if.slave bus,
  output logic [1:0]    dbg_state_o
);

  localparam int CW = (LOCK_MAX > 2) ? $clog2(LOCK_MAX) : 1;
  localparam logic [CW-1:0] REL_AT = CW'(LOCK_MAX - 2);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic          last_q, last_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          rv0_q, rv1_q;
  logic          gnt0, gnt1;
  logic          acc0, acc1;
  logic          force_rel;

  // Grants are combinational and suppressed while reset is held.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!rst) begin
      case (state_q)
        ST_IDLE: begin
          if (bus.m0_req && bus.m1_req) begin
`ifdef DMEM_ARB_RR_EN
            gnt0 = last_q;
            gnt1 = !last_q;
`else
            gnt0 = 1'b1;
`endif
          end else begin
            gnt0 = bus.m0_req;
            gnt1 = bus.m1_req;
          end
        end
        ST_OWN0: gnt0 = bus.m0_req;
        ST_OWN1: gnt1 = bus.m1_req;
        default: begin
          gnt0 = 1'b0;
          gnt1 = 1'b0;
        end
      endcase
    end
  end

  assign acc0 = gnt0 && bus.m0_req;
  assign acc1 = gnt1 && bus.m1_req;

  // Release fires on the cycle whose increment would reach LOCK_MAX-1.
  assign force_rel = (state_q != ST_IDLE) && (cnt_q == REL_AT);

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    if (acc0) last_d = 1'b0;
    if (acc1) last_d = 1'b1;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (acc0 && bus.m0_lock)      state_d = ST_OWN0;
        else if (acc1 && bus.m1_lock) state_d = ST_OWN1;
      end
      ST_OWN0: begin
        cnt_d = cnt_q + CW'(1);
        if (force_rel) begin
          state_d = ST_IDLE;
          last_d  = 1'b0;
        end else if (acc0 && !bus.m0_lock) begin
          state_d = ST_IDLE;
        end
      end
      ST_OWN1: begin
        cnt_d = cnt_q + CW'(1);
        if (force_rel) begin
          state_d = ST_IDLE;
          last_d  = 1'b1;
        end else if (acc1 && !bus.m1_lock) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      last_q  <= 1'b1;
      cnt_q   <= '0;
      rv0_q   <= 1'b0;
      rv1_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      rv0_q   <= acc0 && !bus.m0_we;
      rv1_q   <= acc1 && !bus.m1_we;
    end
  end

  assign bus.m0_gnt = gnt0;
  assign bus.m1_gnt = gnt1;

  assign bus.mem_en    = acc0 || acc1;
  assign bus.mem_we    = acc0 ? bus.m0_we    : (acc1 ? bus.m1_we    : 1'b0);
  assign bus.mem_addr  = acc0 ? bus.m0_addr  : (acc1 ? bus.m1_addr  : '0);
  assign bus.mem_wdata = acc0 ? bus.m0_wdata : (acc1 ? bus.m1_wdata : '0);

  // A response pending when reset arrives is dropped in that same cycle.
  assign bus.m0_rvalid = rv0_q && !rst;
  assign bus.m1_rvalid = rv1_q && !rst;
  assign bus.m0_rdata  = bus.mem_rdata;
  assign bus.m1_rdata  = bus.mem_rdata;

  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a small behavioural single-port memory.
// Expected values are hand-derived; the contention case follows DMEM_ARB_RR_EN.
module tb_dmem_arbiter;

  localparam int DW = 32;
  localparam int AW = 32;
`ifdef DMEM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic [1:0] dbg_state;
  int         n_cmp;
  int         n_err;

  logic [DW-1:0] mem [0:63];
  logic [DW-1:0] rd_q;

  dmem_arbiter_if #(.DW(DW), .AW(AW)) bus ();

  dmem_arbiter #(.DW(DW), .AW(AW), .LOCK_MAX(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus.slave),
    .dbg_state_o (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // memory model: write on strobe, read data registered one cycle later
  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) mem[bus.mem_addr[7:2]] <= bus.mem_wdata;
      else            rd_q <= mem[bus.mem_addr[7:2]];
    end
  end
  assign bus.mem_rdata = rd_q;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_m0(input logic req, input logic we, input logic lock,
                          input logic [31:0] addr, input logic [31:0] wdata);
    bus.m0_req   = req;
    bus.m0_we    = we;
    bus.m0_lock  = lock;
    bus.m0_addr  = addr;
    bus.m0_wdata = wdata;
  endtask

  task automatic drive_m1(input logic req, input logic we, input logic lock,
                          input logic [31:0] addr, input logic [31:0] wdata);
    bus.m1_req   = req;
    bus.m1_we    = we;
    bus.m1_lock  = lock;
    bus.m1_addr  = addr;
    bus.m1_wdata = wdata;
  endtask

  task automatic idle_all();
    drive_m0(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive_m1(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  initial begin
    logic exp_g0, exp_g1, prev_g0, prev_g1;
    int   m1_grants;
    n_cmp = 0;
    n_err = 0;
    for (int i = 0; i < 64; i++) mem[i] = 32'h1000_0000 + 32'(i);
    mem[32'h10 >> 2] = 32'hDEAD_BEEF;
    rd_q = '0;
    rst  = 1'b1;
    idle_all();

    // reset: grants suppressed even with a request present
    drive_m0(1'b1, 1'b0, 1'b0, 32'h10, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_m0_gnt", 32'(bus.m0_gnt), 32'h0);
    check("rst_mem_en", 32'(bus.mem_en), 32'h0);
    check("rst_state", 32'(dbg_state), 32'h0);
    step();
    rst = 1'b0;
    idle_all();
    @(negedge clk);
    check("post_rst_gnt", 32'(bus.m0_gnt), 32'h0);
    check("post_rst_rvalid", 32'(bus.m0_rvalid), 32'h0);

    // single master read
    step();
    drive_m0(1'b1, 1'b0, 1'b0, 32'h10, 32'h0);
    @(negedge clk);
    check("rd_m0_gnt", 32'(bus.m0_gnt), 32'h1);
    check("rd_mem_en", 32'(bus.mem_en), 32'h1);
    check("rd_mem_addr", bus.mem_addr, 32'h10);
    check("rd_mem_we", 32'(bus.mem_we), 32'h0);
    step();
    idle_all();
    @(negedge clk);
    check("rd_m0_rvalid", 32'(bus.m0_rvalid), 32'h1);
    check("rd_m0_rdata", bus.m0_rdata, 32'hDEAD_BEEF);
    check("rd_m1_rvalid", 32'(bus.m1_rvalid), 32'h0);

    // write produces no response, then read back
    step();
    drive_m0(1'b1, 1'b1, 1'b0, 32'h8, 32'h55);
    @(negedge clk);
    check("wr_m0_gnt", 32'(bus.m0_gnt), 32'h1);
    check("wr_mem_we", 32'(bus.mem_we), 32'h1);
    check("wr_mem_wdata", bus.mem_wdata, 32'h55);
    check("wr_mem_addr", bus.mem_addr, 32'h8);
    step();
    drive_m0(1'b1, 1'b0, 1'b0, 32'h8, 32'h0);
    @(negedge clk);
    check("wr_no_rvalid", 32'(bus.m0_rvalid), 32'h0);
    check("rb_m0_gnt", 32'(bus.m0_gnt), 32'h1);
    step();
    idle_all();
    @(negedge clk);
    check("rb_rvalid", 32'(bus.m0_rvalid), 32'h1);
    check("rb_rdata", bus.m0_rdata, 32'h55);
    check("idle_mem_addr", bus.mem_addr, 32'h0);

    // contention from reset
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    prev_g0 = 1'b0;
    prev_g1 = 1'b0;
    for (int k = 0; k < 4; k++) begin
      drive_m0(1'b1, 1'b0, 1'b0, 32'h10, 32'h0);
      drive_m1(1'b1, 1'b0, 1'b0, 32'h14, 32'h0);
      exp_g0 = RR ? (k % 2 == 0) : 1'b1;
      exp_g1 = !exp_g0;
      @(negedge clk);
      check($sformatf("cont_m0_gnt_%0d", k), 32'(bus.m0_gnt), 32'(exp_g0));
      check($sformatf("cont_m1_gnt_%0d", k), 32'(bus.m1_gnt), 32'(exp_g1));
      check($sformatf("cont_m0_rv_%0d", k), 32'(bus.m0_rvalid), 32'(prev_g0));
      check($sformatf("cont_m1_rv_%0d", k), 32'(bus.m1_rvalid), 32'(prev_g1));
      if (prev_g1) check($sformatf("cont_m1_rdata_%0d", k), bus.m1_rdata, 32'h1000_0005);
      prev_g0 = exp_g0;
      prev_g1 = exp_g1;
      step();
    end
    idle_all();
    @(negedge clk);
    check("cont_tail_m0_rv", 32'(bus.m0_rvalid), 32'(prev_g0));
    check("cont_tail_m1_rv", 32'(bus.m1_rvalid), 32'(prev_g1));

    // lock: m1 three writes, m0 waits until the unlocking write is done
    step();
    drive_m1(1'b1, 1'b1, 1'b1, 32'h20, 32'hA0);
    @(negedge clk);
    check("lk0_m1_gnt", 32'(bus.m1_gnt), 32'h1);
    check("lk0_m0_gnt", 32'(bus.m0_gnt), 32'h0);
    step();
    drive_m1(1'b1, 1'b1, 1'b1, 32'h24, 32'hA4);
    drive_m0(1'b1, 1'b0, 1'b0, 32'h10, 32'h0);
    @(negedge clk);
    check("lk1_m1_gnt", 32'(bus.m1_gnt), 32'h1);
    check("lk1_m0_gnt", 32'(bus.m0_gnt), 32'h0);
    check("lk1_state", 32'(dbg_state), 32'h2);
    step();
    drive_m1(1'b1, 1'b1, 1'b0, 32'h28, 32'hA8);
    @(negedge clk);
    check("lk2_m1_gnt", 32'(bus.m1_gnt), 32'h1);
    check("lk2_m0_gnt", 32'(bus.m0_gnt), 32'h0);
    check("lk2_mem_addr", bus.mem_addr, 32'h28);
    step();
    drive_m1(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    check("lk3_m0_gnt", 32'(bus.m0_gnt), 32'h1);
    check("lk3_state", 32'(dbg_state), 32'h0);
    check("lk3_m1_rvalid", 32'(bus.m1_rvalid), 32'h0);
    step();
    idle_all();

    // forced release: m1 locked, m0 waiting
    m1_grants = 0;
    for (int k = 0; k <= 16; k++) begin
      drive_m1(1'b1, 1'b0, 1'b1, 32'h30, 32'h0);
      if (k > 0) drive_m0(1'b1, 1'b0, 1'b0, 32'h10, 32'h0);
      @(negedge clk);
      check($sformatf("fr_m1_gnt_%0d", k), 32'(bus.m1_gnt), 32'(k <= 15));
      check($sformatf("fr_m0_gnt_%0d", k), 32'(bus.m0_gnt), 32'(k == 16));
      if (bus.m1_gnt) m1_grants++;
      step();
    end
    idle_all();
    check("fr_m1_grant_count", 32'(m1_grants), 32'd16);
    @(negedge clk);
    check("fr_end_state", 32'(dbg_state), 32'h0);

    // reset in the cycle after a read grant
    step();
    drive_m0(1'b1, 1'b0, 1'b0, 32'h10, 32'h0);
    @(negedge clk);
    check("rr_m0_gnt", 32'(bus.m0_gnt), 32'h1);
    step();
    idle_all();
    rst = 1'b1;
    @(negedge clk);
    check("rr_rvalid_dropped", 32'(bus.m0_rvalid), 32'h0);
    step();
    rst = 1'b0;
    @(negedge clk);
    check("rr_state", 32'(dbg_state), 32'h0);
    check("rr_rvalid_after", 32'(bus.m0_rvalid), 32'h0);
    step();
    drive_m0(1'b1, 1'b0, 1'b0, 32'h10, 32'h0);
    drive_m1(1'b1, 1'b0, 1'b0, 32'h14, 32'h0);
    @(negedge clk);
    check("rr_first_m0_gnt", 32'(bus.m0_gnt), 32'h1);
    check("rr_first_m1_gnt", 32'(bus.m1_gnt), 32'h0);
    step();
    idle_all();
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
